// File: rtl/sobel_pkg.sv
// Shared types, kernel weights and magnitude helper for the Sobel stream.
package sobel_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic v;
    logic bord;
    logic last;
  } tag_t;

  localparam int KX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  localparam int KY [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  function automatic int sobel_abs_sat(
    input int gx,
    input int gy,
    input int pw
  );
    int ax;
    int ay;
    int s;
    int mx;
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    s  = ax + ay;
    mx = (1 << pw) - 1;
    return (s > mx) ? mx : s;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One-row delay line: reads the entry written DEPTH enables ago,
// then overwrites it, so rdata trails wdata by exactly one image row.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr;

  assign rdata = mem[ptr];

  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel engine with internal line buffers.
// Define SOBEL_THRESH_EN to add the thresh port and binarise the output.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_last
`ifdef SOBEL_THRESH_EN
  ,
  input  logic [PIX_W-1:0] thresh
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int GW = PIX_W + 3;
  localparam logic [PIX_W-1:0] PMAX = '1;

  state_t state;
  logic   rdy_en;
  logic   fl_done;
  logic   adv;
  logic   acc;
  logic   inj;
  logic   in_last;
  logic   in_prime;
  logic   w_emit;
  logic   w_is_last;
  logic   w_bord;

  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic [CW-1:0] wc_col;
  logic [RW-1:0] wc_row;

  logic [PIX_W-1:0] lb1_q;
  logic [PIX_W-1:0] lb2_q;
  logic [PIX_W-1:0] win [9];

  tag_t w_t;
  tag_t s_t;

  int gx_i;
  int gy_i;
  logic signed [GW-1:0] s_gx;
  logic signed [GW-1:0] s_gy;
  logic [PIX_W-1:0] mag;
  logic [PIX_W-1:0] res;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && (state == RUN) && rdy_en;
  assign acc      = in_valid && in_ready;
  assign inj      = adv && (state == FLUSH) && !fl_done;

  assign in_last  = (in_row == RW'(IMG_H - 1))
                 && (in_col == CW'(IMG_W - 1));
  // first full window exists once pixel (1,1) arrives
  assign in_prime = (in_row >= RW'(2))
                 || ((in_row == RW'(1)) && (in_col != '0));
  assign w_emit   = (acc && in_prime) || inj;

  assign w_is_last = (wc_row == RW'(IMG_H - 1))
                  && (wc_col == CW'(IMG_W - 1));
  assign w_bord    = (wc_row == '0)
                  || (wc_row == RW'(IMG_H - 1))
                  || (wc_col == '0)
                  || (wc_col == CW'(IMG_W - 1));

  sobel_line_buf #(
    .DEPTH (IMG_W),
    .W     (PIX_W)
  ) u_lb1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (acc),
    .wdata (in_data),
    .rdata (lb1_q)
  );

  sobel_line_buf #(
    .DEPTH (IMG_W),
    .W     (PIX_W)
  ) u_lb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (acc),
    .wdata (lb1_q),
    .rdata (lb2_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      fl_done <= 1'b0;
      rdy_en  <= 1'b0;
      in_col  <= '0;
      in_row  <= '0;
      wc_col  <= '0;
      wc_row  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (acc) begin
        if (in_col == CW'(IMG_W - 1)) begin
          in_col <= '0;
          in_row <= (in_row == RW'(IMG_H - 1)) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end
      if (w_emit) begin
        if (wc_col == CW'(IMG_W - 1)) begin
          wc_col <= '0;
          wc_row <= (wc_row == RW'(IMG_H - 1)) ? '0 : wc_row + 1'b1;
        end else begin
          wc_col <= wc_col + 1'b1;
        end
      end
      unique case (state)
        RUN: begin
          if (acc && in_last) state <= FLUSH;
        end
        FLUSH: begin
          if (inj && w_is_last) fl_done <= 1'b1;
          if (out_valid && out_ready && out_last) begin
            state   <= RUN;
            fl_done <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else if (acc) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb2_q;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb1_q;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= in_data;
    end
  end

  always_comb begin
    gx_i = 0;
    gy_i = 0;
    for (int i = 0; i < 9; i++) begin
      gx_i = gx_i + KX[i] * int'(win[i]);
      gy_i = gy_i + KY[i] * int'(win[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_t  <= '0;
      s_t  <= '0;
      s_gx <= '0;
      s_gy <= '0;
    end else if (adv) begin
      w_t.v    <= w_emit;
      w_t.bord <= w_bord;
      w_t.last <= w_is_last;
      s_t      <= w_t;
      s_gx     <= GW'(gx_i);
      s_gy     <= GW'(gy_i);
    end
  end

  always_comb begin
    mag = PIX_W'(sobel_abs_sat(int'(s_gx), int'(s_gy), PIX_W));
`ifdef SOBEL_THRESH_EN
    res = (mag >= thresh) ? PMAX : '0;
`else
    res = mag;
`endif
    if (s_t.bord) res = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (adv) begin
      out_valid <= s_t.v;
      out_last  <= s_t.v && s_t.last;
      if (s_t.v) out_data <= res;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream: 4x4 and 5x5 instances, stalls,
// back-to-back frames, mid-frame reset and optional thresholding.
module tb_sobel_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
`ifdef SOBEL_THRESH_EN
  logic [7:0] thresh;
`endif

  logic       v4, r4, ir4, ov4, ol4;
  logic [7:0] d4, od4;
  logic       v5, r5, ir5, ov5, ol5;
  logic [7:0] d5, od5;

  sobel_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v4),
    .in_ready  (ir4),
    .in_data   (d4),
    .out_valid (ov4),
    .out_ready (r4),
    .out_data  (od4),
    .out_last  (ol4)
`ifdef SOBEL_THRESH_EN
    ,
    .thresh    (thresh)
`endif
  );

  sobel_stream #(.PIX_W(8), .IMG_W(5), .IMG_H(5)) u5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v5),
    .in_ready  (ir5),
    .in_data   (d5),
    .out_valid (ov5),
    .out_ready (r5),
    .out_data  (od5),
    .out_last  (ol5)
`ifdef SOBEL_THRESH_EN
    ,
    .thresh    (thresh)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] pix [$];
  logic [7:0] ex  [$];
  logic [7:0] gd  [$];
  logic       gl  [$];
  int         unstable;

  function automatic logic [7:0] tmap(input int m);
`ifdef SOBEL_THRESH_EN
    return (m >= int'(thresh)) ? 8'hFF : 8'h00;
`else
    return 8'(m);
`endif
  endfunction

  // Streams pix[] into one instance and collects nexp outputs.
  task automatic run(input int sel, input int rmode,
                     input int vmode, input int nexp);
    int fi;
    int cyc;
    logic vld, rdy, ir, ov, ol, stalled;
    logic [7:0] od, held;
    fi = 0;
    cyc = 0;
    stalled = 1'b0;
    held = 8'h00;
    unstable = 0;
    gd.delete();
    gl.delete();
    while (gd.size() < nexp && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      vld = (fi < pix.size()) && (vmode == 0 || (cyc % 4) != 3);
      rdy = (rmode == 0) || cyc[0];
      if (sel == 4) begin
        v4 = vld; d4 = vld ? pix[fi] : 8'h00; r4 = rdy;
      end else begin
        v5 = vld; d5 = vld ? pix[fi] : 8'h00; r5 = rdy;
      end
      #1;
      ir = (sel == 4) ? ir4 : ir5;
      ov = (sel == 4) ? ov4 : ov5;
      od = (sel == 4) ? od4 : od5;
      ol = (sel == 4) ? ol4 : ol5;
      if (stalled && (!ov || od !== held)) unstable++;
      if (vld && ir) fi++;
      if (ov && rdy) begin
        gd.push_back(od);
        gl.push_back(ol);
      end
      stalled = ov && !rdy;
      held = od;
    end
    @(negedge clk);
    v4 = 0; v5 = 0; r4 = 1; r5 = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    v4 = 0; d4 = 0; r4 = 1;
    v5 = 0; d5 = 0; r5 = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ir4 !== 1'b0) begin
      errors++; $display("FAIL rst_in_ready got %b want 0", ir4);
    end
    checks++;
    if (ov4 !== 1'b0 || ov5 !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got %b/%b want 0", ov4, ov5);
    end
    checks++;
    if (od4 !== 8'h00) begin
      errors++; $display("FAIL rst_out_data got %0d want 0", od4);
    end
    checks++;
    if (ol4 !== 1'b0) begin
      errors++; $display("FAIL rst_out_last got %b want 0", ol4);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    checks++;
    if (ir4 !== 1'b1 || ir5 !== 1'b1) begin
      errors++; $display("FAIL post_rst_ready got %b/%b want 1", ir4, ir5);
    end
  endtask

  task automatic test_const_4x4();
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(8'd100);
    run(4, 0, 0, 16);
    checks++;
    if (gd.size() != 16) begin
      errors++; $display("FAIL const_count got %0d want 16", gd.size());
    end
    for (int i = 0; i < gd.size(); i++) begin
      checks++;
      if (gd[i] !== 8'h00 || gl[i] !== (i == 15)) begin
        errors++;
        $display("FAIL const_px%0d got %0d/%b want 0/%b",
                 i, gd[i], gl[i], i == 15);
      end
    end
  endtask

  task automatic load_edge5(input logic [7:0] val);
    pix.delete();
    ex.delete();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        pix.push_back(c >= 2 ? val : 8'h00);
        // left and centre windows see the step; right window is flat
        if (r >= 1 && r <= 3 && (c == 1 || c == 2))
          ex.push_back(tmap(val == 8'd200 ? 255 : 120));
        else
          ex.push_back(8'h00);
      end
  endtask

  task automatic test_edge_5x5();
    load_edge5(8'd200);
    run(5, 0, 0, 25);
    checks++;
    if (gd.size() != 25) begin
      errors++; $display("FAIL edge_count got %0d want 25", gd.size());
    end
    for (int i = 0; i < gd.size(); i++) begin
      checks++;
      if (gd[i] !== ex[i] || gl[i] !== (i == 24)) begin
        errors++;
        $display("FAIL edge_px%0d got %0d/%b want %0d/%b",
                 i, gd[i], gl[i], ex[i], i == 24);
      end
    end
  endtask

  task automatic test_stall_5x5();
    load_edge5(8'd200);
    run(5, 1, 1, 25);
    checks++;
    if (gd.size() != 25) begin
      errors++; $display("FAIL stall_count got %0d want 25", gd.size());
    end
    checks++;
    if (unstable != 0) begin
      errors++; $display("FAIL stall_hold got %0d changes want 0", unstable);
    end
    for (int i = 0; i < gd.size(); i++) begin
      checks++;
      if (gd[i] !== ex[i] || gl[i] !== (i == 24)) begin
        errors++;
        $display("FAIL stall_px%0d got %0d/%b want %0d/%b",
                 i, gd[i], gl[i], ex[i], i == 24);
      end
    end
  endtask

  // Peak of 50 at (1,1); neighbours at (1,2),(2,1),(2,2) each see |g|=100.
  task automatic load_peak4(input bit append);
    if (!append) pix.delete();
    ex.delete();
    for (int i = 0; i < 16; i++) begin
      pix.push_back(i == 5 ? 8'd50 : 8'd0);
      ex.push_back((i == 6 || i == 9 || i == 10) ? tmap(100) : 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    int nl;
    pix.delete();
    for (int i = 0; i < 16; i++) pix.push_back(8'd77);
    load_peak4(1'b1);
    run(4, 0, 0, 32);
    checks++;
    if (gd.size() != 32) begin
      errors++; $display("FAIL b2b_count got %0d want 32", gd.size());
    end
    nl = 0;
    for (int i = 0; i < gd.size(); i++) begin
      checks++;
      nl += int'(gl[i]);
      if (i < 16 && (gd[i] !== 8'h00 || gl[i] !== (i == 15))) begin
        errors++;
        $display("FAIL b2b_f1_px%0d got %0d/%b want 0/%b",
                 i, gd[i], gl[i], i == 15);
      end
      if (i >= 16 && (gd[i] !== ex[i-16] || gl[i] !== (i == 31))) begin
        errors++;
        $display("FAIL b2b_f2_px%0d got %0d/%b want %0d/%b",
                 i - 16, gd[i], gl[i], ex[i-16], i == 31);
      end
    end
    checks++;
    if (nl != 2) begin
      errors++; $display("FAIL b2b_lasts got %0d want 2", nl);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    r4 = 0;
    while (n < 7 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      v4 = 1;
      d4 = 8'(n * 9);
      #1;
      if (ir4) n++;
    end
    @(negedge clk);
    v4 = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (n != 7 || ov4 !== 1'b1) begin
      errors++; $display("FAIL mid_prefill got %0d/%b want 7/1", n, ov4);
    end
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (ov4 !== 1'b0 || ol4 !== 1'b0 || od4 !== 8'h00 || ir4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got v%b l%b d%0d r%b want all 0",
               ov4, ol4, od4, ir4);
    end
    @(negedge clk);
    rst_n = 1;
    r4 = 1;
    @(negedge clk);
    load_peak4(1'b0);
    run(4, 0, 0, 16);
    checks++;
    if (gd.size() != 16) begin
      errors++; $display("FAIL mid_count got %0d want 16", gd.size());
    end
    for (int i = 0; i < gd.size(); i++) begin
      checks++;
      if (gd[i] !== ex[i] || gl[i] !== (i == 15)) begin
        errors++;
        $display("FAIL mid_px%0d got %0d/%b want %0d/%b",
                 i, gd[i], gl[i], ex[i], i == 15);
      end
    end
  endtask

`ifdef SOBEL_THRESH_EN
  task automatic test_thresh();
    load_edge5(8'd30);
    run(5, 0, 0, 25);
    checks++;
    if (gd.size() != 25) begin
      errors++; $display("FAIL thr_count got %0d want 25", gd.size());
    end
    for (int i = 0; i < gd.size(); i++) begin
      checks++;
      if (gd[i] !== ex[i]) begin
        errors++;
        $display("FAIL thr_px%0d got %0d want %0d", i, gd[i], ex[i]);
      end
    end
  endtask
`endif

  initial begin
`ifdef SOBEL_THRESH_EN
    thresh = 8'd100;
`endif
    test_reset();
    test_const_4x4();
    test_edge_5x5();
    test_stall_5x5();
    test_back_to_back();
    test_reset_mid();
`ifdef SOBEL_THRESH_EN
    test_thresh();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
